// File: rtl/dffnq_deser.sv
// Falling-edge serial-to-parallel capture for a dffnq-style bit stream.
// Assembles WIDTH-bit words and hands them off over a valid/ready pair with a sticky overflow flag.
`timescale 1ns/1ps
module dffnq_deser #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             CLKN,
    input  logic             RN,
    input  logic             D,
    input  logic             DV,
    input  logic             SOF,
    output logic [WIDTH-1:0] Q,
    output logic             QV,
    input  logic             QR,
    output logic             OVF,
    input  logic             CLR_OVF
);
    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] shreg;

    logic             restart;
    logic             take;
    logic             done;
    logic             pop;
    logic             drop;
    logic [CW-1:0]    pos;
    logic [WIDTH-1:0] word_nxt;

    // Positions not yet written are zero, so OR-ing the new bit in is enough.
    function automatic logic [WIDTH-1:0] insert_bit(input logic [WIDTH-1:0] base,
                                                    input logic [CW-1:0]    k,
                                                    input logic             d);
        logic [CW-1:0] sh;
        sh = MSB_FIRST ? (LAST - k) : k;
        return base | (WIDTH'(d) << sh);
    endfunction

    always_comb begin
        restart  = DV & SOF;
        take     = DV & (SOF | (state == SHIFT));
        pos      = restart ? '0 : cnt;
        word_nxt = insert_bit((pos == '0) ? '0 : shreg, pos, D);
        done     = take & (pos == LAST);
        pop      = QV & QR;
        drop     = done & QV & ~QR;
    end

    always_ff @(negedge CLKN or negedge RN) begin
        if (!RN) begin
            state <= IDLE;
            cnt   <= '0;
            shreg <= '0;
            Q     <= '0;
            QV    <= 1'b0;
            OVF   <= 1'b0;
        end else begin
            if (take) begin
                state <= SHIFT;
                shreg <= word_nxt;
                cnt   <= done ? '0 : pos + 1'b1;
            end
            // A completion refills the holding register unless the consumer is stalled.
            if (done && !drop) begin
                Q  <= word_nxt;
                QV <= 1'b1;
            end else if (pop) begin
                QV <= 1'b0;
            end
            if (drop) begin
                OVF <= 1'b1;
            end else if (CLR_OVF) begin
                OVF <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_dffnq_deser.sv
// Bench for dffnq_deser: MSB-first and LSB-first instances share one stimulus stream
// and are checked against a queue-based word model plus hand-computed vectors.
`timescale 1ns/1ps
module tb_dffnq_deser;
    logic       CLKN = 1'b1;
    logic       RN = 1'b1, D = 1'b0, DV = 1'b0, SOF = 1'b0, QR = 1'b0, CLR_OVF = 1'b0;
    logic [7:0] q_m, q_l;
    logic       qv_m, qv_l, ovf_m, ovf_l;

    dffnq_deser #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
        .CLKN(CLKN), .RN(RN), .D(D), .DV(DV), .SOF(SOF),
        .Q(q_m), .QV(qv_m), .QR(QR), .OVF(ovf_m), .CLR_OVF(CLR_OVF));
    dffnq_deser #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
        .CLKN(CLKN), .RN(RN), .D(D), .DV(DV), .SOF(SOF),
        .Q(q_l), .QV(qv_l), .QR(QR), .OVF(ovf_l), .CLR_OVF(CLR_OVF));

    always #5 CLKN = ~CLKN;

    int nvec  = 0;
    int nfail = 0;

    // Reference model: received bits of the current word kept in a queue.
    bit         bits[$];
    bit         inframe;
    logic [7:0] eqm, eql;
    logic       eqv, eovf;

    typedef struct {
        logic       rn, d, dv, sof, qr, clr;
        logic [7:0] eqm, eql;
        logic       eqv, eovf;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(logic rn, logic d, logic dv, logic sof, logic qr, logic clr,
                                logic [7:0] xm, logic [7:0] xl, logic xv, logic xo);
        vec_t v;
        v.rn = rn; v.d = d; v.dv = dv; v.sof = sof; v.qr = qr; v.clr = clr;
        v.eqm = xm; v.eql = xl; v.eqv = xv; v.eovf = xo;
        tbl.push_back(v);
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s at %0t: got %0h, want %0h", nm, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        bits.delete();
        inframe = 1'b0;
        eqm = '0; eql = '0; eqv = 1'b0; eovf = 1'b0;
    endtask

    task automatic model_edge();
        bit         complete;
        bit         pop_e, drop_e;
        logic [7:0] wm, wl;
        complete = 1'b0; wm = '0; wl = '0;
        if (!RN) begin
            model_reset();
        end else begin
            if (DV && SOF) begin
                bits.delete();
                bits.push_back(D);
                inframe = 1'b1;
            end else if (DV && inframe) begin
                bits.push_back(D);
            end
            if (bits.size() == 8) begin
                complete = 1'b1;
                for (int k = 0; k < 8; k++) begin
                    wm = wm * 2 + 8'(bits[k]);
                    wl = wl | (8'(bits[k]) << k);
                end
                bits.delete();
            end
            pop_e  = eqv && QR;
            drop_e = complete && eqv && !QR;
            if (complete && !drop_e) begin
                eqm = wm; eql = wl; eqv = 1'b1;
            end else if (pop_e) begin
                eqv = 1'b0;
            end
            if (drop_e) eovf = 1'b1;
            else if (CLR_OVF) eovf = 1'b0;
        end
    endtask

    task automatic tick();
        @(negedge CLKN);
        model_edge();
        #1;
        cmp("q_msb", q_m, eqm);
        cmp("q_lsb", q_l, eql);
        cmp("qv_msb", qv_m, eqv);
        cmp("qv_lsb", qv_l, eqv);
        cmp("ovf_msb", ovf_m, eovf);
        cmp("ovf_lsb", ovf_l, eovf);
    endtask

    task automatic send_bit(input logic d, input logic sof);
        D = d; DV = 1'b1; SOF = sof;
        tick();
        DV = 1'b0; SOF = 1'b0;
    endtask

    // Sends the first n bits of v so that the MSB-first instance sees v.
    task automatic send(input logic [7:0] v, input bit sof_first, input int n);
        for (int k = 0; k < n; k++) send_bit(v[7-k], sof_first && (k == 0));
    endtask

    task automatic idle(input int n);
        DV = 1'b0; SOF = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        model_reset();
        #1 RN = 1'b0;
        #1;
        cmp("async_rst_q", q_m, 8'h00);
        cmp("async_rst_qv", qv_m, 1'b0);
        cmp("async_rst_ovf", ovf_m, 1'b0);

        // rn d dv sof qr clr | q_msb q_lsb qv ovf
        add(0, 1, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0);
        add(0, 0, 1, 1, 0, 0, 8'h00, 8'h00, 0, 0);
        add(0, 1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0);
        add(1, 1, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0);
        add(1, 0, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0);
        add(1, 1, 1, 1, 0, 0, 8'h00, 8'h00, 0, 0);
        add(1, 0, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0);
        add(1, 1, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0);
        add(1, 0, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0);
        add(1, 0, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0);
        add(1, 1, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0);
        add(1, 0, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0);
        add(1, 1, 1, 0, 0, 0, 8'hA5, 8'hA5, 1, 0);
        add(1, 0, 0, 0, 1, 0, 8'hA5, 8'hA5, 0, 0);
        add(1, 1, 1, 1, 0, 0, 8'hA5, 8'hA5, 0, 0);
        add(1, 1, 1, 0, 0, 0, 8'hA5, 8'hA5, 0, 0);
        add(1, 0, 1, 0, 0, 0, 8'hA5, 8'hA5, 0, 0);
        add(1, 0, 1, 0, 0, 0, 8'hA5, 8'hA5, 0, 0);
        add(1, 0, 1, 0, 0, 0, 8'hA5, 8'hA5, 0, 0);
        add(1, 0, 1, 0, 0, 0, 8'hA5, 8'hA5, 0, 0);
        add(1, 0, 1, 0, 0, 0, 8'hA5, 8'hA5, 0, 0);
        add(1, 0, 1, 0, 0, 0, 8'hC0, 8'h03, 1, 0);
        add(1, 0, 0, 0, 1, 0, 8'hC0, 8'h03, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            RN = tbl[i].rn; D = tbl[i].d; DV = tbl[i].dv; SOF = tbl[i].sof;
            QR = tbl[i].qr; CLR_OVF = tbl[i].clr;
            tick();
            cmp($sformatf("tbl%0d_q_msb", i), q_m, tbl[i].eqm);
            cmp($sformatf("tbl%0d_q_lsb", i), q_l, tbl[i].eql);
            cmp($sformatf("tbl%0d_qv", i), qv_m, tbl[i].eqv);
            cmp($sformatf("tbl%0d_ovf", i), ovf_m, tbl[i].eovf);
        end
        RN = 1'b1; QR = 1'b0; CLR_OVF = 1'b0; DV = 1'b0; SOF = 1'b0;

        // Back-to-back words with a two-edge gap inside the second
        QR = 1'b1;
        send(8'h3C, 1'b1, 8);
        cmp("b2b_first_q", q_m, 8'h3C);
        cmp("b2b_first_qv", qv_m, 1'b1);
        send(8'hFF, 1'b0, 4);
        idle(2);
        for (int k = 4; k < 8; k++) send_bit(1'b1, 1'b0);
        cmp("b2b_second_q", q_m, 8'hFF);
        cmp("b2b_second_qv", qv_m, 1'b1);
        cmp("b2b_ovf", ovf_m, 1'b0);
        idle(1);

        // Overflow, clear, and coincident drop/clear
        QR = 1'b0;
        send(8'h11, 1'b1, 8);
        send(8'h22, 1'b0, 8);
        cmp("ovf_q_kept", q_m, 8'h11);
        cmp("ovf_set", ovf_m, 1'b1);
        CLR_OVF = 1'b1;
        idle(1);
        cmp("ovf_cleared", ovf_m, 1'b0);
        send(8'h44, 1'b0, 8);
        cmp("ovf_set_wins", ovf_m, 1'b1);
        cmp("ovf_set_wins_q", q_m, 8'h11);
        CLR_OVF = 1'b0;
        QR = 1'b1;
        idle(1);
        QR = 1'b0;

        // Resync discards a partial word
        send(8'hFF, 1'b1, 5);
        cmp("resync_partial_qv", qv_m, 1'b0);
        send(8'h81, 1'b1, 8);
        cmp("resync_q", q_m, 8'h81);
        cmp("resync_qv", qv_m, 1'b1);
        QR = 1'b1;
        idle(1);
        QR = 1'b0;

        // Mid-word asynchronous reset
        send(8'hF0, 1'b1, 4);
        RN = 1'b0;
        #2;
        model_reset();
        cmp("midword_rst_q", q_m, 8'h00);
        cmp("midword_rst_qv", qv_m, 1'b0);
        idle(1);
        RN = 1'b1;
        send(8'h5A, 1'b1, 8);
        cmp("after_rst_q", q_m, 8'h5A);

        // Zero-bubble: pop and completion on the same edge
        send(8'hC3, 1'b0, 7);
        cmp("zb_hold_q", q_m, 8'h5A);
        QR = 1'b1;
        send_bit(1'b1, 1'b0);
        cmp("zb_q", q_m, 8'hC3);
        cmp("zb_qv", qv_m, 1'b1);
        cmp("zb_ovf", ovf_m, 1'b0);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            RN      = ($urandom_range(0, 63) != 0);
            D       = 1'($urandom);
            DV      = ($urandom_range(0, 3) != 0);
            SOF     = ($urandom_range(0, 9) == 0);
            QR      = 1'($urandom);
            CLR_OVF = ($urandom_range(0, 15) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
